// File: rtl/a_fifo_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// The read register resets to zero so the FIFO output is never X.
module a_fifo_ram #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDRESS_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0]    wdata,
    input  logic                     re,
    input  logic [ADDRESS_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0]    rdata
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_r;

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/a_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Pointers carry an extra wrap bit to distinguish full from empty.
module a_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    output logic                  full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty
);

    localparam int PTR_WIDTH = ADDRESS_WIDTH + 1;

    logic [PTR_WIDTH-1:0] wptr_r;
    logic [PTR_WIDTH-1:0] rptr_r;
    logic                 full_s;
    logic                 empty_s;
    logic                 wr_accept_s;
    logic                 rd_accept_s;

    // Flags and request qualification, all against pre-edge pointer state.
    always_comb begin
        empty_s     = (wptr_r == rptr_r);
        full_s      = (wptr_r[ADDRESS_WIDTH-1:0] == rptr_r[ADDRESS_WIDTH-1:0]) &&
                      (wptr_r[ADDRESS_WIDTH] != rptr_r[ADDRESS_WIDTH]);
        wr_accept_s = wr_en && !full_s && !rst;
        rd_accept_s = rd_en && !empty_s && !rst;
    end

    // Pointer registers; wrap naturally modulo 2**PTR_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r <= {PTR_WIDTH{1'b0}};
            rptr_r <= {PTR_WIDTH{1'b0}};
        end else begin
            if (wr_accept_s) begin
                wptr_r <= wptr_r + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                wptr_r <= wptr_r;
            end
            if (rd_accept_s) begin
                rptr_r <= rptr_r + {{(PTR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                rptr_r <= rptr_r;
            end
        end
    end

    a_fifo_ram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_ram (
        .clk  (clk),
        .rst  (rst),
        .we   (wr_accept_s),
        .waddr(wptr_r[ADDRESS_WIDTH-1:0]),
        .wdata(data_in),
        .re   (rd_accept_s),
        .raddr(rptr_r[ADDRESS_WIDTH-1:0]),
        .rdata(data_out)
    );

    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: tb/tb_a_fifo.sv
// Directed self-checking bench for a_fifo at depth 8 (ADDRESS_WIDTH=3).
module tb_a_fifo;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       wr_en;
    logic       full;
    logic       rd_en;
    logic [7:0] data_out;
    logic       empty;

    int total;
    int bad;

    a_fifo #(
        .DATA_WIDTH   (8),
        .ADDRESS_WIDTH(3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .wr_en   (wr_en),
        .full    (full),
        .rd_en   (rd_en),
        .data_out(data_out),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic w, input logic [7:0] d, input logic r);
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic e, input logic f);
        chk({tag, "_empty"}, 32'(empty), 32'(e));
        chk({tag, "_full"}, 32'(full), 32'(f));
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = 8'h00;
        @(posedge clk);
        #1;
        step(1'b0, 8'h00, 1'b0);
        rst = 1'b0;

        // Reset state and reads while empty
        chk_flags("reset", 1'b1, 1'b0);
        chk("reset_dout", 32'(data_out), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("rd_empty_dout", 32'(data_out), 32'h0);
            chk("rd_empty_flag", 32'(empty), 32'h1);
        end

        // Basic order and latency
        step(1'b1, 8'h11, 1'b0);
        chk_flags("w1", 1'b0, 1'b0);
        chk("no_fallthrough", 32'(data_out), 32'h0);
        step(1'b1, 8'h22, 1'b0);
        step(1'b1, 8'h33, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("rd1", 32'(data_out), 32'h11);
        step(1'b0, 8'h00, 1'b1);
        chk("rd2", 32'(data_out), 32'h22);
        step(1'b0, 8'h00, 1'b1);
        chk("rd3", 32'(data_out), 32'h33);
        chk_flags("rd3", 1'b1, 1'b0);

        // Fill to capacity, overflow write dropped, drain
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i), 1'b0);
            chk("fill_full", 32'(full), (i == 7) ? 32'h1 : 32'h0);
        end
        step(1'b1, 8'hAA, 1'b0);
        chk_flags("overflow", 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain", 32'(data_out), 32'(i));
            chk("drain_empty", 32'(empty), (i == 7) ? 32'h1 : 32'h0);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("hold_after_drain", 32'(data_out), 32'h7);

        // Wrap: three full fill/drain rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 8'(r * 8 + i), 1'b0);
            end
            chk_flags("wrap_full", 1'b0, 1'b1);
            for (int i = 0; i < 8; i++) begin
                step(1'b0, 8'h00, 1'b1);
                chk("wrap_data", 32'(data_out), 32'(r * 8 + i));
            end
            chk_flags("wrap_empty", 1'b1, 1'b0);
        end

        // Simultaneous read/write with 4 stored
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b0);
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 8'(8'h44 + k), 1'b1);
            chk("sim_data", 32'(data_out), 32'(8'h40 + k));
            chk_flags("sim", 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("sim_tail", 32'(data_out), 32'(8'h54 + i));
        end
        chk_flags("sim_tail", 1'b1, 1'b0);

        // Simultaneous at full: write dropped
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'h60 + i), 1'b0);
        end
        step(1'b1, 8'h70, 1'b1);
        chk("simfull_data", 32'(data_out), 32'h60);
        chk_flags("simfull", 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("simfull_drain", 32'(data_out), 32'(8'h60 + i));
        end
        chk_flags("simfull_drain", 1'b1, 1'b0);

        // Simultaneous at empty: read dropped
        step(1'b1, 8'h80, 1'b1);
        chk("simempty_hold", 32'(data_out), 32'h67);
        chk_flags("simempty", 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("simempty_rd", 32'(data_out), 32'h80);
        chk_flags("simempty_rd", 1'b1, 1'b0);

        // Reset mid-stream with 5 stored, reset overrides requests
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'(8'h90 + i), 1'b0);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("pre_rst_rd", 32'(data_out), 32'h90);
        rst = 1'b1;
        step(1'b1, 8'hEE, 1'b1);
        rst = 1'b0;
        chk_flags("midrst", 1'b1, 1'b0);
        chk("midrst_dout", 32'(data_out), 32'h0);
        step(1'b1, 8'h5A, 1'b0);
        chk_flags("post_rst_w", 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_rd", 32'(data_out), 32'h5A);
        chk_flags("post_rst_rd", 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
